decoder_2to4_stream: RTL and testbench

//  Streaming binary-to-one-hot decoder; the inverse of the team's 4:2 encoders.

---
 rtl/decoder_2to4_stream.sv | 114 +++++++++++
 tb/tb_decoder_2to4_stream.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_2to4_stream.sv
// Streaming binary-to-one-hot decoder with a 2-entry output skid FIFO and
// saturating per-line hit counters, updated on each popped word.
module decoder_2to4_stream #(
    parameter  int SEL_W = 2,
    parameter  int CNT_W = 8,
    localparam int OUT_W = 1 << SEL_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_en,
    input  logic [SEL_W-1:0]       in_code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_onehot,
    input  logic                   cnt_clr,
    output logic [OUT_W*CNT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [OUT_W-1:0]              head_q, head_d;
    logic [OUT_W-1:0]              tail_q, tail_d;
    logic [OUT_W-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]              word;
    logic                          push;
    logic                          pop;

    // rst_n gates in_ready so nothing is offered as accepted while in reset.
    assign in_ready   = rst_n && (state_q != FULL);
    assign out_valid  = (state_q != EMPTY);
    assign out_onehot = head_q;
    assign hit_cnt    = cnt_q;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    always_comb begin
        word = '0;
        if (in_en) begin
            word[in_code] = 1'b1;
        end
    end

    // head_q is forced to zero whenever the FIFO drains so out_onehot=0 when idle.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = word;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = word;
                end else if (push) begin
                    tail_d  = word;
                    state_d = FULL;
                end else if (pop) begin
                    head_d  = '0;
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    tail_d  = '0;
                    state_d = ONE;
                end
            end
            default: begin
                head_d  = '0;
                tail_d  = '0;
                state_d = EMPTY;
            end
        endcase
    end

    // Clear wins over a same-cycle increment; counters stop at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < OUT_W; k++) begin
            if (cnt_clr) begin
                cnt_d[k] = '0;
            end else if (pop && head_q[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_decoder_2to4_stream.sv
// Directed bench for decoder_2to4_stream: main instance with default widths,
// second instance with 2-bit counters for saturation and clear.
module tb_decoder_2to4_stream;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, in_en, out_valid, out_ready, cnt_clr;
    logic [1:0]  in_code;
    logic [3:0]  out_onehot;
    logic [31:0] hit_cnt;

    logic        v2, rdy2_in, en2, ov2, or2, clr2;
    logic [1:0]  code2;
    logic [3:0]  oh2;
    logic [7:0]  hit2;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt [4];

    always #5 clk = ~clk;

    decoder_2to4_stream #(.SEL_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_en(in_en), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
        .cnt_clr(cnt_clr), .hit_cnt(hit_cnt)
    );

    decoder_2to4_stream #(.SEL_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v2), .in_ready(rdy2_in), .in_en(en2), .in_code(code2),
        .out_valid(ov2), .out_ready(or2), .out_onehot(oh2),
        .cnt_clr(clr2), .hit_cnt(hit2)
    );

    typedef struct {
        logic       en;
        logic [1:0] code;
        logic [3:0] exp_oh;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_hit();
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(exp_cnt[k]);
        return v;
    endfunction

    task automatic add_hits(input logic [3:0] w);
        for (int k = 0; k < 4; k++) if (w[k] && exp_cnt[k] < 255) exp_cnt[k]++;
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 2'd0, 4'b0001};
        vecs[1] = '{1'b1, 2'd1, 4'b0010};
        vecs[2] = '{1'b1, 2'd2, 4'b0100};
        vecs[3] = '{1'b1, 2'd3, 4'b1000};
        vecs[4] = '{1'b0, 2'd3, 4'b0000};
        vecs[5] = '{1'b1, 2'd2, 4'b0100};
        vecs[6] = '{1'b0, 2'd1, 4'b0000};
        vecs[7] = '{1'b1, 2'd1, 4'b0010};
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;

        rst_n = 1'b0; in_valid = 1'b1; in_en = 1'b1; in_code = 2'd2;
        out_ready = 1'b1; cnt_clr = 1'b0;
        v2 = 1'b0; en2 = 1'b1; code2 = 2'd0; or2 = 1'b1; clr2 = 1'b0;

        // T1 reset held with in_valid high
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_onehot", out_onehot, 4'b0);
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_hit_cnt", hit_cnt, 32'h0);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);

        // T2 / T5 streamed table, out_ready high, one word per cycle
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_en = vecs[i].en; in_code = vecs[i].code;
            step();
            chk($sformatf("stream_valid_%0d", i), out_valid, 1'b1);
            chk($sformatf("stream_onehot_%0d", i), out_onehot, vecs[i].exp_oh);
            chk($sformatf("stream_in_ready_%0d", i), in_ready, 1'b1);
            chk($sformatf("stream_hit_%0d", i), hit_cnt, exp_hit());
            add_hits(vecs[i].exp_oh);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain_valid", out_valid, 1'b0);
        chk("stream_drain_onehot", out_onehot, 4'b0);
        chk("stream_hit_final", hit_cnt, 32'h01_02_02_01);
        chk("stream_hit_model", hit_cnt, exp_hit());

        // T3 backpressure: 2,3 accepted, 1 stalls
        out_ready = 1'b0; in_valid = 1'b1; in_en = 1'b1; in_code = 2'd2;
        step();
        chk("bp_first_in_ready", in_ready, 1'b1);
        chk("bp_first_onehot", out_onehot, 4'b0100);
        in_code = 2'd3;
        step();
        chk("bp_full_in_ready", in_ready, 1'b0);
        in_code = 2'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_in_ready", in_ready, 1'b0);
            chk("bp_hold_onehot", out_onehot, 4'b0100);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_hit", hit_cnt, exp_hit());
        end
        out_ready = 1'b1;
        step();
        add_hits(4'b0100);
        chk("bp_rel1_onehot", out_onehot, 4'b1000);
        chk("bp_rel1_in_ready", in_ready, 1'b1);
        step();
        add_hits(4'b1000);
        chk("bp_rel2_onehot", out_onehot, 4'b0010);
        in_valid = 1'b0;
        step();
        add_hits(4'b0010);
        chk("bp_drain_valid", out_valid, 1'b0);
        chk("bp_hit", hit_cnt, exp_hit());

        // T4 push+pop at occupancy 1 for 10 words
        for (int i = 0; i < 10; i++) begin
            logic [1:0] c;
            logic [3:0] w;
            c = 2'((i * 3) % 4);
            w = 4'b0001 << c;
            in_valid = 1'b1; in_en = 1'b1; in_code = c;
            step();
            chk($sformatf("pp_onehot_%0d", i), out_onehot, w);
            chk($sformatf("pp_in_ready_%0d", i), in_ready, 1'b1);
            add_hits(w);
        end
        in_valid = 1'b0;
        step();
        chk("pp_drain_valid", out_valid, 1'b0);
        chk("pp_hit", hit_cnt, exp_hit());

        // Reset while FIFO full discards everything
        out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd3;
        step();
        step();
        chk("mid_full_in_ready", in_ready, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_onehot", out_onehot, 4'b0);
        chk("mid_rst_hit", hit_cnt, 32'h0);
        step();
        chk("mid_rst_stays_empty", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);

        // T6 saturation and clear on the CNT_W=2 instance
        v2 = 1'b1; en2 = 1'b1; code2 = 2'd0; or2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("sat_cnt_%0d", k), hit2, 8'((k - 1 > 3) ? 3 : k - 1));
        end
        v2 = 1'b0;
        step();
        chk("sat_cnt_hold", hit2, 8'h03);
        v2 = 1'b1;
        step();
        v2 = 1'b0; clr2 = 1'b1;
        chk("clr_pre_valid", ov2, 1'b1);
        step();
        clr2 = 1'b0;
        chk("clr_priority", hit2, 8'h00);
        chk("clr_drain_valid", ov2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
